// File: rtl/divider_iterative_pkg.sv
// rtl/divider_iterative_pkg.sv - shared M-extension opcodes, divider state type and helpers
package divider_iterative_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam logic [1:0] OP_DIV    = 2'b00;
    localparam logic [1:0] OP_DIVU   = 2'b01;
    localparam logic [1:0] OP_REM    = 2'b10;
    localparam logic [1:0] OP_REMU   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    // Negation is done in 33 bits so that 0x80000000 yields magnitude 2^31, not a corrupted value.
    function automatic logic [31:0] abs_mag(input logic [31:0] x);
        logic [32:0] wide;
        wide = {x[31], x};
        if (x[31]) begin
            wide = ~wide + 33'd1;
        end
        return wide[31:0];
    endfunction

endpackage

// File: rtl/divider_iterative.sv
// rtl/divider_iterative.sv - iterative restoring divider, one quotient bit per cycle
module divider_iterative
    import divider_iterative_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        startE,
    input  logic [1:0]  div_opcode,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic [31:0] result_divide,
    output logic        done,
    output logic        div_use
);

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        is_rem_q, is_rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        spec_q, spec_d;
    logic [31:0] spec_res_q, spec_res_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;
    logic        div_use_q, div_use_d;

    logic        start_signed;
    logic        start_rem;
    logic        div_zero;
    logic        signed_ovf;
    logic [32:0] shifted;
    logic [32:0] trial;

    assign start_signed = ~div_opcode[0];
    assign start_rem    = div_opcode[1];
    assign div_zero     = (operand2 == 32'd0);
    assign signed_ovf   = start_signed && (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        is_rem_d   = is_rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        result_d   = result_q;
        done_d     = 1'b0;
        div_use_d  = div_use_q;
        shifted    = {rem_q, dvd_q[31]};
        trial      = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (startE) begin
                    is_rem_d  = start_rem;
                    neg_quo_d = start_signed && (operand1[31] ^ operand2[31]);
                    neg_rem_d = start_signed && operand1[31];
                    dvd_d     = start_signed ? abs_mag(operand1) : operand1;
                    dvs_d     = start_signed ? abs_mag(operand2) : operand2;
                    rem_d     = 32'd0;
                    cnt_d     = 5'd0;
                    div_use_d = 1'b1;
                    spec_d    = div_zero || signed_ovf;
                    if (div_zero) begin
                        spec_res_d = start_rem ? operand1 : 32'hFFFF_FFFF;
                    end else begin
                        spec_res_d = start_rem ? 32'd0 : 32'h8000_0000;
                    end
                    state_d = (div_zero || signed_ovf) ? FINISH : CALC;
                end
            end
            CALC: begin
                // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (spec_q) begin
                    result_d = spec_res_q;
                end else if (is_rem_q) begin
                    result_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
                end else begin
                    result_d = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
                end
                done_d    = 1'b1;
                div_use_d = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 32'd0;
            result_q   <= 32'd0;
            done_q     <= 1'b0;
            div_use_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            is_rem_q   <= is_rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            result_q   <= result_d;
            done_q     <= done_d;
            div_use_q  <= div_use_d;
        end
    end

    assign result_divide = result_q;
    assign done          = done_q;
    assign div_use       = div_use_q;

endmodule

// File: tb/tb_divider_iterative.sv
// tb/tb_divider_iterative.sv - scoreboard-driven self-checking bench for divider_iterative
module tb_divider_iterative;

    logic        clk;
    logic        rst_n;
    logic        startE;
    logic [1:0]  div_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [31:0] result_divide;
    logic        done;
    logic        div_use;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   passed;
    int   total;

    divider_iterative dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .startE        (startE),
        .div_opcode    (div_opcode),
        .operand1      (operand1),
        .operand2      (operand2),
        .result_divide (result_divide),
        .done          (done),
        .div_use       (div_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Entered and left just after a falling edge with the DUT idle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        exp_t e;
        int   cyc;
        logic seen;
        e.res = model(op, a, b);
        e.lat = model_lat(op, a, b);
        sb.push_back(e);
        startE = 1'b1; div_opcode = op; operand1 = a; operand2 = b;
        @(negedge clk);
        startE = 1'b0;
        cyc = 1;
        total++;
        if (div_use !== 1'b1) $display("FAIL %s div_use_cycle1 got %0b want 1", name, div_use);
        else passed++;
        seen = done;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            $display("FAIL %s timeout no done after %0d cycles", name, cyc);
        end else begin
            passed++;
            total++;
            if (cyc != e.lat) $display("FAIL %s latency got %0d want %0d", name, cyc, e.lat);
            else passed++;
            total++;
            if (result_divide !== e.res) $display("FAIL %s result got %h want %h", name, result_divide, e.res);
            else passed++;
            total++;
            if (div_use !== 1'b0) $display("FAIL %s div_use_in_done got %0b want 0", name, div_use);
            else passed++;
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || div_use !== 1'b0)
            $display("FAIL %s after_done done=%0b div_use=%0b want 0/0", name, done, div_use);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; startE = 1'b0; div_opcode = 2'b00; operand1 = 0; operand2 = 0;
        repeat (3) @(negedge clk);
        total++;
        if (result_divide !== 32'd0 || done !== 1'b0 || div_use !== 1'b0)
            $display("FAIL reset_state got res=%h done=%0b use=%0b want 0/0/0", result_divide, done, div_use);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        run_op(2'b01, 32'd100, 32'd7, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        run_op(2'b11, 32'd3, 32'hFFFF_FFFF, "remu_small_big");
    endtask

    task automatic test_signed();
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
        run_op(2'b00, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
        run_op(2'b10, 32'h8000_0000, 32'd3, "rem_min_3");
    endtask

    task automatic test_div_zero();
        run_op(2'b00, 32'd5, 32'd0, "div_5_0");
        run_op(2'b11, 32'd5, 32'd0, "remu_5_0");
        run_op(2'b10, 32'hFFFF_FFFD, 32'd0, "rem_m3_0");
    endtask

    task automatic test_overflow();
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_not_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(op, a, b, "random");
        end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   cyc;
        logic seen;
        e.res = model(2'b01, 32'd1000, 32'd9);
        e.lat = 34;
        sb.push_back(e);
        startE = 1'b1; div_opcode = 2'b01; operand1 = 32'd1000; operand2 = 32'd9;
        @(negedge clk);
        startE = 1'b0;
        cyc = 1;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            if (cyc == 10) begin
                startE = 1'b1; div_opcode = 2'b10; operand1 = 32'd77; operand2 = 32'd0;
            end
            @(negedge clk);
            startE = 1'b0;
            cyc++;
            seen = done;
        end
        e = sb.pop_front();
        total++;
        if (!seen || cyc != e.lat || result_divide !== e.res)
            $display("FAIL start_ignored seen=%0b cyc=%0d res=%h want cyc=%0d res=%h", seen, cyc, result_divide, e.lat, e.res);
        else passed++;
        // Request presented while the DUT sits in DONE must be dropped.
        startE = 1'b1; div_opcode = 2'b01; operand1 = 32'd50; operand2 = 32'd5;
        @(negedge clk);
        startE = 1'b0;
        total++;
        if (div_use !== 1'b0 || done !== 1'b0)
            $display("FAIL start_in_done div_use=%0b done=%0b want 0/0", div_use, done);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (div_use !== 1'b0 || result_divide !== e.res)
            $display("FAIL start_in_done_hold div_use=%0b res=%h want 0/%h", div_use, result_divide, e.res);
        else passed++;
    endtask

    task automatic test_reset_mid_calc();
        startE = 1'b1; div_opcode = 2'b01; operand1 = 32'hDEAD_BEEF; operand2 = 32'd3;
        @(negedge clk);
        startE = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (result_divide !== 32'd0 || done !== 1'b0 || div_use !== 1'b0)
            $display("FAIL reset_mid_calc res=%h done=%0b use=%0b want 0/0/0", result_divide, done, div_use);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'd9, 32'd3, "divu_9_3_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 32'd12345, 32'd123, "b2b_1");
        run_op(2'b10, 32'hFFFF_0000, 32'd0, "b2b_2");
        run_op(2'b11, 32'd12345, 32'd123, "b2b_3");
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_random();
        test_start_ignored();
        test_reset_mid_calc();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
